// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// the bit-period helper used by both the transmitter and future receiver.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Truncating division: the bit period is rounded down to whole clocks.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock
// of each bit; clear holds the count at zero.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits; the serial line is driven from a register.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic        LAST_STOP    = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q,   idx_d;
    logic       stop_q,  stop_d;
    logic       par_q,   par_d;
    logic       tx_q,    tx_d;
    logic       done;
    logic       tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == TX_IDLE),
        .tick (tick)
    );

    // tx_d always carries the value of the bit that starts on the next edge.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_start_i) begin
                    shreg_d = tx_data_i;
                    par_d   = (PARITY == PARITY_EVEN) ? ^tx_data_i : ~^tx_data_i;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            tx_d    = par_q;
                            state_d = TX_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                            state_d = TX_STOP;
                        end
                    end else begin
                        tx_d  = shreg_q[1];
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        done    = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_ready_o = (state_q == TX_IDLE);
    assign tx_done_o  = done;
    assign tx_o       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations compared every cycle against a
// frame-level model, plus hand-computed timing and line-content figures.
module tb_uart_tx;

    localparam int LIMIT = 6000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start;
    logic [7:0] data [4];
    logic [3:0] ready;
    logic [3:0] done;
    logic [3:0] txl;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(50000000), .BAUD(115200), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_start_i(start[0]), .tx_data_i(data[0]),
        .tx_ready_o(ready[0]), .tx_done_o(done[0]), .tx_o(txl[0]));
    uart_tx #(.CLK_FREQ(50000000), .BAUD(115200), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_start_i(start[1]), .tx_data_i(data[1]),
        .tx_ready_o(ready[1]), .tx_done_o(done[1]), .tx_o(txl[1]));
    uart_tx #(.CLK_FREQ(50000000), .BAUD(115200), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_start_i(start[2]), .tx_data_i(data[2]),
        .tx_ready_o(ready[2]), .tx_done_o(done[2]), .tx_o(txl[2]));
    uart_tx #(.CLK_FREQ(8), .BAUD(1), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_start_i(start[3]), .tx_data_i(data[3]),
        .tx_ready_o(ready[3]), .tx_done_o(done[3]), .tx_o(txl[3]));

    // Per-instance frame model: bit period, frame length in bits, parity mode.
    int unsigned m_cpb [4] = '{434, 434, 434, 8};
    int unsigned m_nb  [4] = '{10, 11, 11, 11};
    int unsigned m_par [4] = '{0, 2, 1, 0};
    logic        m_busy [4];
    int unsigned m_t    [4];
    logic [11:0] m_frame [4];

    function automatic logic [11:0] frame_of(input int unsigned par, input logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (par == 2) f[9] = ^d;
        else if (par == 1) f[9] = ~^d;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_t[i]    <= 0;
            end else if (m_busy[i]) begin
                if (m_t[i] == m_nb[i] * m_cpb[i] - 1) m_busy[i] <= 1'b0;
                else m_t[i] <= m_t[i] + 1;
            end else if (start[i] === 1'b1) begin
                m_frame[i] <= frame_of(m_par[i], data[i]);
                m_busy[i]  <= 1'b1;
                m_t[i]     <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("u%0d tx_o", i), 32'(txl[i]),
                      32'(m_busy[i] ? m_frame[i][m_t[i] / m_cpb[i]] : 1'b1));
                check($sformatf("u%0d tx_ready_o", i), 32'(ready[i]), 32'(!m_busy[i]));
                check($sformatf("u%0d tx_done_o", i), 32'(done[i]),
                      32'(m_busy[i] && (m_t[i] == m_nb[i] * m_cpb[i] - 1)));
            end
        end
    end

    task automatic run_frame(input int i, input logic [7:0] d, input logic [7:0] d_after,
                             output int done_at, output int ready_low, output int done_cnt,
                             output int low_cnt, output int stop_run);
        int run;
        bit finished;
        @(negedge clk);
        start[i] = 1'b1;
        data[i]  = d;
        @(negedge clk);
        start[i] = 1'b0;
        data[i]  = d_after;
        done_at = 0; ready_low = 0; done_cnt = 0; low_cnt = 0; stop_run = 0;
        run = 0; finished = 1'b0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            if (ready[i]) begin
                finished = 1'b1;
                break;
            end
            ready_low++;
            if (!txl[i]) begin
                low_cnt++;
                run = 0;
            end else begin
                run++;
            end
            if (done[i]) begin
                done_cnt++;
                done_at  = cyc;
                stop_run = run;
            end
            @(negedge clk);
        end
        if (!finished) check($sformatf("u%0d frame timeout", i), 0, 1);
    endtask

    initial begin
        int da, rl, dc, lc, sr;
        int dones, gaps, cycles;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("reset tx_o", 32'(txl), 32'hF);
        check("reset tx_ready_o", 32'(ready), 32'hF);
        check("reset tx_done_o", 32'(done), 32'h0);
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(0, 8'hA5, 8'hA5, da, rl, dc, lc, sr);
        check("A5 done clk", da, 4340);
        check("A5 ready low clks", rl, 4340);
        check("A5 done pulses", dc, 1);
        check("A5 low clks", lc, 2170);

        // Streaming: three frames of 0x55 with one idle clock between them.
        @(negedge clk);
        start[0] = 1'b1;
        data[0]  = 8'h55;
        @(negedge clk);
        dones = 0; gaps = 0; cycles = 0;
        for (int cyc = 1; cyc <= 3 * LIMIT; cyc++) begin
            cycles = cyc;
            if (ready[0]) gaps++;
            if (done[0]) begin
                dones++;
                if (dones == 3) begin
                    start[0] = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        check("stream done pulses", dones, 3);
        check("stream idle gaps", gaps, 2);
        check("stream length", cycles, 13022);
        repeat (2) @(negedge clk);
        check("stream stops", 32'(ready[0]), 1);

        run_frame(0, 8'h00, 8'hFF, da, rl, dc, lc, sr);
        check("00 low clks", lc, 3906);
        check("00 done clk", da, 4340);

        // Abort a frame in the middle of data bit 4.
        @(negedge clk);
        start[0] = 1'b1;
        data[0]  = 8'hC3;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5 * 434 + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort tx_o", 32'(txl[0]), 1);
        check("abort tx_ready_o", 32'(ready[0]), 1);
        check("abort tx_done_o", 32'(done[0]), 0);
        rst = 1'b0;
        run_frame(0, 8'h3C, 8'h3C, da, rl, dc, lc, sr);
        check("3C done clk", da, 4340);
        check("3C low clks", lc, 2170);
        check("3C done pulses", dc, 1);

        run_frame(1, 8'h07, 8'h07, da, rl, dc, lc, sr);
        check("even 07 done clk", da, 4774);
        check("even 07 low clks", lc, 2604);
        run_frame(2, 8'h07, 8'h07, da, rl, dc, lc, sr);
        check("odd 07 done clk", da, 4774);
        check("odd 07 low clks", lc, 3038);

        run_frame(3, 8'h01, 8'h01, da, rl, dc, lc, sr);
        check("2stop done clk", da, 88);
        check("2stop high run", sr, 16);
        check("2stop low clks", lc, 64);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
